imem_port_arbiter: RTL
======================

Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory port between the pipeline IF stage (fetch, read-only) and a program loader/debug port (read/write).
- Sits between the IF stage and the instruction memory, which has a combinational read path. The arbiter adds MEM_LAT wait states per access and a stall to the pipeline.
- One outstanding transaction at a time. The loader has priority, with a starvation guard that protects fetch.

Parameters:
ADDR_W, 32 (`ADDRESS_LEN), address width
DATA_W, 32 (`WORD_LEN), instruction word width
MEM_LAT, 1, wait cycles from issue to data capture (1..15)
MAX_STARVE, 4, consecutive loader grants allowed while fetch waits (1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
fetch_req  in  1  fetch request; held until fetch_ack
fetch_adr  in  ADDR_W  fetch word address
fetch_ack  out  1  1-cycle pulse: fetch request accepted
fetch_valid  out  1  1-cycle pulse: fetch_data valid
fetch_data  out  DATA_W  fetched instruction; holds until next fetch_valid
ld_req  in  1  loader request; held until ld_ack
ld_we  in  1  1 = write, 0 = read
ld_adr  in  ADDR_W  loader word address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  1-cycle pulse: loader request accepted
ld_valid  out  1  1-cycle pulse: loader access complete
ld_rdata  out  DATA_W  loader read data; holds until next read completion
mem_en  out  1  memory access active (ISSUE and WAIT)
mem_we  out  1  write strobe, high only in ISSUE cycle of a write
mem_adr  out  ADDR_W  registered memory address, stable ISSUE..WAIT
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data
stall_out  out  1  combinational: fetch_req & ~fetch_valid

Behaviour:
- Reset: all outputs 0, state IDLE, owner = none, wait counter 0, starve counter 0. Reset mid-transaction drops the access silently: no valid, no ack, no write completes after reset release.
- States:
  - IDLE: sample requests on each edge.
  - ISSUE: one cycle; mem_en=1; mem_we=1 if loader write.
  - WAIT: MEM_LAT cycles, counter down from MEM_LAT-1.
  - DONE: one cycle; capture mem_rdata into the owner's data register; pulse owner's valid; return to IDLE.
- Timing:
  - Grant edge (IDLE->ISSUE) registers owner, mem_adr, mem_wdata, mem_we and pulses the owner's ack for the following cycle.
  - A request seen at edge N gives valid in cycle N+MEM_LAT+2.
  - Max throughput is one access per MEM_LAT+3 cycles.
- Arbitration in IDLE:
  - Loader only, or both requesting with starve < MAX_STARVE: grant loader. If fetch_req=1, starve += 1 (saturating).
  - Fetch only, or both requesting with starve == MAX_STARVE: grant fetch; starve := 0.
  - Neither requesting: stay IDLE; starve unchanged.
- Requests and hold:
  - A request deasserted before ack is ignored, with no error.
  - The requester may reassert in the cycle after ack; that new request is a new transaction.
  - Address and data need only be stable in the cycle of the granting edge.
- Loader access completion:
  - Loader write: ld_valid pulses in DONE; ld_rdata unchanged.
  - Loader read: ld_rdata updated.
- Same-address conflict: a loader write granted ahead of a same-address fetch is fully complete before the fetch issues. The fetch returns the new word.
- Idle outputs: fetch_data and ld_rdata hold their last value. mem_adr and mem_wdata hold their last value in IDLE; mem_en=0 in IDLE and DONE.
- stall_out is purely combinational from current fetch_req and fetch_valid, and is 0 during reset.

Test Plan:
- Reset, then fetch_req=1, adr=10, memory[10]=0x8C0100FC, MEM_LAT=1 -> fetch_ack in cycle 1, fetch_valid in cycle 3 with fetch_data=0x8C0100FC; stall_out=1 in cycles 0-2, 0 in cycle 3.
- Loader write adr=0, data=0x0800000A, concurrent fetch_req adr=0 -> loader granted first; mem_we high exactly one cycle; ld_valid pulses; fetch then returns 0x0800000A.
- ld_req and fetch_req held continuously, MAX_STARVE=4 -> grant sequence L,L,L,L,F,L,L,L,L,F; starve returns to 0 after each F.
- MEM_LAT=3 loader read adr=252 -> ld_valid exactly 5 cycles after the granting edge; mem_adr=252 stable for ISSUE plus 3 WAIT cycles.
- rst low during WAIT of a fetch -> all outputs 0 immediately; no fetch_valid after release; new fetch adr=11 completes normally.
- fetch_req pulsed 1 cycle while a loader transaction is busy, then dropped -> no fetch_ack, no fetch_valid; starve counter unchanged.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - instruction-memory port arbiter between fetch and loader/debug
module imem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side (read-only)
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_adr,
  output logic              fetch_ack,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  // loader / debug side
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // pipeline stall
  output logic              stall_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LD} owner_t;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  state_t     state;
  state_t     state_nxt;
  owner_t     owner;
  logic       owner_we;
  logic [3:0] wait_cnt;
  logic [3:0] starve;
  logic       grant_ld;
  logic       grant_f;

  // Arbitration: loader wins unless fetch has already waited MAX_STARVE grants.
  always_comb begin
    grant_ld = 1'b0;
    grant_f  = 1'b0;
    if (state == S_IDLE) begin
      if (ld_req && (!fetch_req || (starve < STARVE_MAX))) begin
        grant_ld = 1'b1;
      end else if (fetch_req) begin
        grant_f = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: ISSUE for one cycle, MEM_LAT wait cycles, DONE for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_ld || grant_f) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the granted request, count wait states, capture read data
  // on the last wait edge so the owner's data is valid alongside its valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= OWN_NONE;
      owner_we    <= 1'b0;
      wait_cnt    <= 4'd0;
      starve      <= 4'd0;
      fetch_ack   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      ld_ack      <= 1'b0;
      ld_valid    <= 1'b0;
      ld_rdata    <= '0;
      mem_we      <= 1'b0;
      mem_adr     <= '0;
      mem_wdata   <= '0;
    end else begin
      fetch_ack   <= 1'b0;
      ld_ack      <= 1'b0;
      fetch_valid <= 1'b0;
      ld_valid    <= 1'b0;
      mem_we      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ld) begin
            owner     <= OWN_LD;
            owner_we  <= ld_we;
            mem_adr   <= ld_adr;
            mem_wdata <= ld_wdata;
            mem_we    <= ld_we;
            ld_ack    <= 1'b1;
            if (fetch_req && (starve < STARVE_MAX)) begin
              starve <= starve + 4'd1;
            end
          end else if (grant_f) begin
            owner     <= OWN_FETCH;
            owner_we  <= 1'b0;
            mem_adr   <= fetch_adr;
            fetch_ack <= 1'b1;
            starve    <= 4'd0;
          end
        end
        S_ISSUE: begin
          wait_cnt <= LAT_M1;
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (owner == OWN_LD) begin
              ld_valid <= 1'b1;
              if (!owner_we) begin
                ld_rdata <= mem_rdata;
              end
            end else if (owner == OWN_FETCH) begin
              fetch_valid <= 1'b1;
              fetch_data  <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: begin
          owner    <= OWN_NONE;
          owner_we <= 1'b0;
        end
        default: begin
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign mem_en    = (state == S_ISSUE) || (state == S_WAIT);
  assign stall_out = rst & fetch_req & ~fetch_valid;

endmodule
